// File: rtl/vscpu_pkg.sv
// Shared opcodes, FSM states and instruction field helpers for the multi-cycle vscpu core.
// Field helpers take the address width at call time so one package serves any ADDR_W.
package vscpu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_SRL  = 3'd2;
  localparam logic [2:0] OP_LT   = 3'd3;
  localparam logic [2:0] OP_CP   = 3'd4;
  localparam logic [2:0] OP_CPI  = 3'd5;
  localparam logic [2:0] OP_BZJ  = 3'd6;
  localparam logic [2:0] OP_MUL  = 3'd7;

  localparam int AW_MAX = 32;
  localparam int IW_MAX = 2 * AW_MAX + 4;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_RD_A, S_RD_B, S_RD_IND, S_EXEC, S_WB, S_HALT
  } state_e;

  function automatic logic [AW_MAX-1:0] f_mask(input int aw);
    return (AW_MAX'(1) << aw) - AW_MAX'(1);
  endfunction

  // Instruction layout: {op[2:0], i, A[aw-1:0], B[aw-1:0]}
  function automatic logic [2:0] f_op(input logic [IW_MAX-1:0] w, input int aw);
    return 3'(w >> (2 * aw + 1));
  endfunction

  function automatic logic f_i(input logic [IW_MAX-1:0] w, input int aw);
    return 1'(w >> (2 * aw));
  endfunction

  function automatic logic [AW_MAX-1:0] f_a(input logic [IW_MAX-1:0] w, input int aw);
    return AW_MAX'(w >> aw) & f_mask(aw);
  endfunction

  function automatic logic [AW_MAX-1:0] f_b(input logic [IW_MAX-1:0] w, input int aw);
    return AW_MAX'(w) & f_mask(aw);
  endfunction

  function automatic logic reads_a(input logic [2:0] op, input logic i);
    return (op != OP_CP && op != OP_CPI) || (op == OP_CPI && i);
  endfunction

  function automatic logic reads_b(input logic [2:0] op, input logic i);
    return !i || (op == OP_CPI);
  endfunction

endpackage

// File: rtl/vscpu_mc_core_if.sv
// Single req/ack memory port: master holds req/we/addr/wdata until ack; rdata valid with ack.
interface vscpu_mc_core_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/vscpu_alu.sv
// Combinational arithmetic for ADD NAND SRL LT MUL; zero latency, no flow control.
module vscpu_alu
  import vscpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);
  localparam logic [DATA_W-1:0] DW1 = DATA_W'(DATA_W);
  localparam logic [DATA_W-1:0] DW2 = DATA_W'(2 * DATA_W);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_NAND: y = ~(a & b);
      OP_LT:   y = {{(DATA_W - 1){1'b0}}, (a < b)};
      OP_MUL:  y = a * b;
      // Shift counts past the word width turn the right shift into a left shift.
      OP_SRL: begin
        if (b < DW1)      y = a >> b;
        else if (b < DW2) y = a << (b - DW1);
      end
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/vscpu_mc_core.sv
// Multi-cycle memory-to-memory CPU: 4..6 cycles per instruction at zero wait, plus memory stalls.
// Stalls on mem_ack with request held; halt_req parks the core only at an instruction boundary.
module vscpu_mc_core
  import vscpu_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  vscpu_mc_core_if.master   mem,
  input  logic              halt_req,
  output logic              halted,
  output logic              retire,
  output logic [CNT_W-1:0]  instr_count
);
  if (DATA_W < 2 * ADDR_W + 4) begin : g_width_check
    $error("vscpu_mc_core: DATA_W too small to hold an instruction");
  end

  state_e             state, state_n;
  logic [ADDR_W-1:0]  pc, pc_n, pc_inc, br_tgt, fa, fb;
  logic [DATA_W-1:0]  iw, ra, rb, op2, alu_res, result, b_ext;
  logic [2:0]         op;
  logic               imm, done, do_retire;
  logic               req_q, we_q, req_n, we_n;
  logic [ADDR_W-1:0]  addr_q, addr_n;
  logic [DATA_W-1:0]  wdata_q, wdata_n;

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign op     = f_op(IW_MAX'(iw), ADDR_W);
  assign imm    = f_i(IW_MAX'(iw), ADDR_W);
  assign fa     = ADDR_W'(f_a(IW_MAX'(iw), ADDR_W));
  assign fb     = ADDR_W'(f_b(IW_MAX'(iw), ADDR_W));
  assign b_ext  = {{(DATA_W - ADDR_W){1'b0}}, fb};
  assign op2    = imm ? b_ext : rb;
  assign done   = req_q && mem.mem_ack;
  assign pc_inc = pc + ADDR_W'(1);
  assign br_tgt = imm ? (ra[ADDR_W-1:0] + fb) : ((rb == '0) ? ra[ADDR_W-1:0] : pc_inc);
  // CPI moves the (possibly indirected) *B; CP moves op2.
  assign result = (op == OP_CP) ? op2 : (op == OP_CPI) ? rb : alu_res;

  vscpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op (op),
    .a  (ra),
    .b  (op2),
    .y  (alu_res)
  );

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    req_n     = 1'b0;
    we_n      = 1'b0;
    addr_n    = addr_q;
    wdata_n   = wdata_q;
    do_retire = 1'b0;
    case (state)
      S_FETCH:  if (done) state_n = S_DECODE;
      S_DECODE: begin
        if (reads_a(op, imm))      state_n = S_RD_A;
        else if (reads_b(op, imm)) state_n = S_RD_B;
        else                       state_n = S_EXEC;
      end
      S_RD_A:   if (done) state_n = reads_b(op, imm) ? S_RD_B : S_EXEC;
      S_RD_B:   if (done) state_n = (op == OP_CPI && !imm) ? S_RD_IND : S_EXEC;
      S_RD_IND: if (done) state_n = S_EXEC;
      S_EXEC: begin
        if (op == OP_BZJ) begin
          do_retire = 1'b1;
          pc_n      = br_tgt;
        end else begin
          state_n = S_WB;
          wdata_n = result;
        end
      end
      S_WB: begin
        if (done) begin
          do_retire = 1'b1;
          pc_n      = pc_inc;
        end
      end
      S_HALT:   if (!halt_req) state_n = S_FETCH;
      default:  state_n = S_FETCH;
    endcase
    if (do_retire) state_n = halt_req ? S_HALT : S_FETCH;

    // Request for the state being entered is issued on the same edge, so a
    // zero-wait memory completes each access state in one cycle.
    case (state_n)
      S_FETCH:  begin req_n = 1'b1; addr_n = pc_n; end
      S_RD_A:   begin req_n = 1'b1; addr_n = fa; end
      S_RD_B:   begin req_n = 1'b1; addr_n = fb; end
      S_RD_IND: begin
        req_n  = 1'b1;
        addr_n = (state == S_RD_B) ? mem.mem_rdata[ADDR_W-1:0] : rb[ADDR_W-1:0];
      end
      S_WB: begin
        req_n  = 1'b1;
        we_n   = 1'b1;
        addr_n = (op == OP_CPI && imm) ? ra[ADDR_W-1:0] : fa;
      end
      default: req_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      pc          <= '0;
      iw          <= '0;
      ra          <= '0;
      rb          <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      halted      <= 1'b0;
      retire      <= 1'b0;
      instr_count <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      req_q   <= req_n;
      we_q    <= we_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      halted  <= (state_n == S_HALT);
      retire  <= do_retire;
      if (do_retire) instr_count <= instr_count + CNT_W'(1);
      if (done) begin
        case (state)
          S_FETCH:          iw <= mem.mem_rdata;
          S_RD_A:           ra <= mem.mem_rdata;
          S_RD_B, S_RD_IND: rb <= mem.mem_rdata;
          default:          ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_vscpu_mc_core.sv
// Scoreboard bench: program load queues expected writes and post-retire fetch addresses/latencies.
// Random 0..3 cycle ack delay per access; halt and reset-during-write-wait sequences at the end.
module tb_vscpu_mc_core;
  import vscpu_pkg::*;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst;
  logic halt_req, halted, retire;
  logic [CW-1:0] instr_count;

  always #5 clk = ~clk;

  vscpu_mc_core_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

  vscpu_mc_core #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem         (mif),
    .halt_req    (halt_req),
    .halted      (halted),
    .retire      (retire),
    .instr_count (instr_count)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [63:0] wr_q[$];
  int exp_pc_q[$];
  int exp_lat_q[$];
  int n_vec = 0, n_err = 0, n_ret = 0;
  int cyc = 0, last_cyc = 0, stalls = 0, dly = 0;
  bit hold_wr = 1'b0, lat_valid = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lat_of(input logic [2:0] op, input logic i);
    case (op)
      OP_BZJ, OP_CP: return i ? 4 : 5;
      OP_CPI:        return 6;
      default:       return i ? 5 : 6;
    endcase
  endfunction

  task automatic put(input int a, input logic [2:0] op, input logic i, input int fa, input int fb,
                     input int npc, input bit wr, input int wa, input logic [31:0] wd);
    mem[a] = {op, i, 14'(fa), 14'(fb)};
    exp_pc_q.push_back(npc);
    exp_lat_q.push_back(lat_of(op, i));
    if (wr) wr_q.push_back({18'b0, 14'(wa), wd});
  endtask

  task automatic wait_ret(input int n);
    for (int k = 0; k < 400 && n_ret < n; k++) @(negedge clk);
    chk("wait_retire", n_ret, n);
  endtask

  task automatic chk_rst_outputs();
    chk("rst_mem_req", mif.mem_req, 0);
    chk("rst_mem_we", mif.mem_we, 0);
    chk("rst_mem_addr", mif.mem_addr, 0);
    chk("rst_mem_wdata", mif.mem_wdata, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retire", retire, 0);
    chk("rst_instr_count", instr_count, 0);
  endtask

  // Memory model: ack/rdata driven away from the active edge; stray acks while idle.
  always @(negedge clk) begin
    if (mif.mem_req === 1'b1)
      mif.mem_ack = (dly == 0) && !(hold_wr && mif.mem_we);
    else
      mif.mem_ack = ($urandom_range(0, 1) == 1);
    mif.mem_rdata = mem[mif.mem_addr];
  end

  always @(posedge clk) begin
    cyc++;
    if (!rst && mif.mem_req === 1'b1) begin
      if (mif.mem_ack === 1'b1) begin
        if (mif.mem_we) begin
          chk("wr_expected", wr_q.size() != 0, 1);
          if (wr_q.size() != 0) chk("wr_addr_data", {18'b0, mif.mem_addr, mif.mem_wdata}, wr_q.pop_front());
          mem[mif.mem_addr] = mif.mem_wdata;
        end
        dly = $urandom_range(0, 3);
      end else begin
        stalls++;
        if (dly > 0) dly--;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && retire === 1'b1) begin
      int npc, lat;
      n_ret++;
      chk("instr_count", instr_count, 64'(16'(n_ret)));
      chk("retire_expected", exp_pc_q.size() != 0, 1);
      if (exp_pc_q.size() != 0) begin
        npc = exp_pc_q.pop_front();
        lat = exp_lat_q.pop_front();
        if (lat_valid) chk("latency", cyc - last_cyc, lat + stalls);
        if (!halted) chk("next_fetch", {mif.mem_req, mif.mem_addr}, {1'b1, 14'(npc)});
      end
      last_cyc  = cyc;
      stalls    = 0;
      lat_valid = !halted;
    end
  end

  initial begin
    int cnt;
    rst = 1'b1;
    halt_req = 1'b0;
    for (int k = 0; k < (1 << AW); k++) mem[k] = '0;
    mem[100] = 7;            mem[101] = 5;
    mem[102] = 32'hFFFF_FFFF;
    mem[103] = 32'h8000_0001; mem[104] = 32'h8000_0001; mem[105] = 32'h8000_0001;
    mem[200] = 300;          mem[300] = 9;   mem[51] = 4;
    mem[106] = 32'hF0F0_F0F0; mem[107] = 32'hFF00_FF00;
    mem[108] = 32'h0001_0001; mem[109] = 32'h0003_0003;
    mem[111] = 32'hDEAD_BEEF; mem[113] = 5;  mem[114] = 3;
    mem[115] = 40;           mem[116] = 0;   mem[117] = 1;  mem[118] = 16383;
    mem[119] = 3;            mem[120] = 7;   mem[121] = 0;
    put(0,  OP_ADD,  0, 100, 101, 1,  1, 100, 12);
    put(1,  OP_ADD,  1, 102, 1,   2,  1, 102, 0);
    put(2,  OP_LT,   1, 102, 3,   3,  1, 102, 1);
    put(3,  OP_SRL,  1, 103, 1,   4,  1, 103, 32'h4000_0000);
    put(4,  OP_SRL,  1, 104, 33,  5,  1, 104, 32'h0000_0002);
    put(5,  OP_SRL,  1, 105, 64,  6,  1, 105, 0);
    put(6,  OP_CPI,  0, 50,  200, 7,  1, 50,  9);
    put(7,  OP_CPI,  1, 200, 51,  8,  1, 300, 4);
    put(8,  OP_NAND, 0, 106, 107, 9,  1, 106, 32'h0FFF_0FFF);
    put(9,  OP_MUL,  0, 108, 109, 10, 1, 108, 32'h0006_0003);
    put(10, OP_CP,   0, 110, 111, 11, 1, 110, 32'hDEAD_BEEF);
    put(11, OP_CP,   1, 112, 16'h1234, 12, 1, 112, 32'h0000_1234);
    put(12, OP_LT,   0, 113, 114, 13, 1, 113, 0);
    put(13, OP_BZJ,  0, 115, 116, 40, 0, 0, 0);
    put(40, OP_BZJ,  0, 115, 117, 41, 0, 0, 0);
    put(41, OP_BZJ,  1, 118, 43,  42, 0, 0, 0);
    put(42, OP_MUL,  0, 119, 120, 43, 1, 119, 21);
    put(43, OP_ADD,  1, 121, 1,   44, 1, 121, 1);
    mem[44] = {OP_ADD, 1'b0, 14'd122, 14'd123};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_rst_outputs();
    rst = 1'b0;

    wait_ret(16);
    repeat (2) @(negedge clk);
    halt_req = 1'b1;
    wait_ret(17);
    chk("halted_after_mul", halted, 1);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      cnt += int'(mif.mem_req);
    end
    chk("halt_no_req", cnt, 0);
    chk("halt_count_frozen", instr_count, 17);
    halt_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mif.mem_req) break;
    end
    chk("resume_fetch", {mif.mem_req, mif.mem_addr}, {1'b1, 14'd43});
    chk("resume_halted", halted, 0);

    wait_ret(18);
    hold_wr = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (mif.mem_req && mif.mem_we) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("wb_waiting", {mif.mem_req, mif.mem_we, mif.mem_addr}, {2'b11, 14'd122});
    rst = 1'b1;
    lat_valid = 1'b0;
    @(negedge clk);
    chk_rst_outputs();
    hold_wr = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mif.mem_req) break;
    end
    chk("fetch_after_rst", {mif.mem_req, mif.mem_addr}, {1'b1, 14'd0});
    rst = 1'b1;
    @(negedge clk);
    chk("writes_drained", wr_q.size(), 0);
    chk("retires_drained", exp_pc_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
